// File: rtl/wb_stage_if.sv
// MEM-to-WB bundle for the RV32I writeback stage.
// MEM drives it through master; WB consumes it through slave.
interface wb_stage_if;
   logic        i_valid_MEM;
   logic        i_reg_write_MEM;
   logic [1:0]  i_result_src_MEM;
   logic [2:0]  i_funct3_MEM;
   logic [31:0] i_alu_result_MEM;
   logic [31:0] i_data_MEM;
   logic [11:7] i_addr_des_MEM;
   logic [31:0] i_pc_plus4_MEM;

   modport master (
      output i_valid_MEM,
      output i_reg_write_MEM,
      output i_result_src_MEM,
      output i_funct3_MEM,
      output i_alu_result_MEM,
      output i_data_MEM,
      output i_addr_des_MEM,
      output i_pc_plus4_MEM
   );

   modport slave (
      input i_valid_MEM,
      input i_reg_write_MEM,
      input i_result_src_MEM,
      input i_funct3_MEM,
      input i_alu_result_MEM,
      input i_data_MEM,
      input i_addr_des_MEM,
      input i_pc_plus4_MEM
   );
endinterface

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB register, load extraction,
// result select, register-file write port and instret counter.
module wb_stage #(
   parameter int CNT_W       = 64,
   parameter bit EN_MISALIGN = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   wb_stage_if.slave        mem,
   input  logic             i_stall,
   input  logic             i_flush,
   output logic [31:0]      o_result_WB,
   output logic [11:7]      o_addr_des_WB,
   output logic             o_reg_write_WB,
   output logic             o_valid_WB,
   output logic             o_misaligned_WB,
   output logic [CNT_W-1:0] o_instret
);

   logic             r_valid;
   logic             r_reg_write;
   logic [1:0]       r_result_src;
   logic [2:0]       r_funct3;
   logic [31:0]      r_alu;
   logic [31:0]      r_data;
   logic [11:7]      r_rd;
   logic [31:0]      r_pc4;
   logic [CNT_W-1:0] r_instret;

   logic [1:0]       w_off;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_load;
   logic             w_mis_raw;
   logic             w_mis;
   logic [31:0]      w_result;
   logic             w_retire;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid      <= 1'b0;
         r_reg_write  <= 1'b0;
         r_result_src <= 2'b00;
         r_funct3     <= 3'b000;
         r_alu        <= 32'h0;
         r_data       <= 32'h0;
         r_rd         <= 5'd0;
         r_pc4        <= 32'h0;
      end else begin
         priority case (1'b1)
            i_flush: begin
               r_valid      <= 1'b0;
               r_reg_write  <= 1'b0;
               r_result_src <= 2'b00;
               r_funct3     <= 3'b000;
               r_alu        <= 32'h0;
               r_data       <= 32'h0;
               r_rd         <= 5'd0;
               r_pc4        <= 32'h0;
            end
            i_stall: ;
            default: begin
               r_valid      <= mem.i_valid_MEM;
               r_reg_write  <= mem.i_reg_write_MEM;
               r_result_src <= mem.i_result_src_MEM;
               r_funct3     <= mem.i_funct3_MEM;
               r_alu        <= mem.i_alu_result_MEM;
               r_data       <= mem.i_data_MEM;
               r_rd         <= mem.i_addr_des_MEM;
               r_pc4        <= mem.i_pc_plus4_MEM;
            end
         endcase
      end
   end

   // A flushed-while-stalled entry is still leaving WB, so it retires.
   assign w_retire = r_valid & (~i_stall | i_flush);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_instret <= '0;
      else if (w_retire)
         r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign w_off  = r_alu[1:0];
   assign w_half = r_alu[1] ? r_data[31:16] : r_data[15:0];

   always_comb begin
      w_byte = r_data[7:0];
      unique case (w_off)
         2'd0: w_byte = r_data[7:0];
         2'd1: w_byte = r_data[15:8];
         2'd2: w_byte = r_data[23:16];
         2'd3: w_byte = r_data[31:24];
      endcase
   end

   always_comb begin
      w_load    = 32'h0;
      w_mis_raw = 1'b0;
      case (r_funct3)
         3'b000: w_load = {{24{w_byte[7]}}, w_byte};
         3'b100: w_load = {24'h0, w_byte};
         3'b001: begin
            w_load    = {{16{w_half[15]}}, w_half};
            w_mis_raw = w_off[0];
         end
         3'b101: begin
            w_load    = {16'h0, w_half};
            w_mis_raw = w_off[0];
         end
         3'b010: begin
            w_load    = r_data;
            w_mis_raw = (w_off != 2'b00);
         end
         default: begin
            w_load    = 32'h0;
            w_mis_raw = 1'b1;
         end
      endcase
   end

   assign w_mis = EN_MISALIGN
                & (r_result_src == 2'b01)
                & w_mis_raw;

   always_comb begin
      w_result = 32'h0;
      case (r_result_src)
         2'b00:   w_result = r_alu;
         2'b01:   w_result = w_load;
         2'b10:   w_result = r_pc4;
         default: w_result = 32'h0;
      endcase
   end

   assign o_result_WB     = w_result;
   assign o_addr_des_WB   = r_rd;
   assign o_valid_WB      = r_valid;
   assign o_misaligned_WB = r_valid & w_mis;
   assign o_reg_write_WB  = r_reg_write & r_valid
                          & (r_rd != 5'd0) & ~w_mis;
   assign o_instret       = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Directed vector bench for wb_stage: a default instance and a
// second one with the misalign check off and a 4-bit counter.
module tb_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;

   logic [31:0] res_a;
   logic [11:7] rd_a;
   logic        we_a;
   logic        v_a;
   logic        mis_a;
   logic [63:0] cnt_a;

   logic [31:0] res_b;
   logic [11:7] rd_b;
   logic        we_b;
   logic        v_b;
   logic        mis_b;
   logic [3:0]  cnt_b;

   wb_stage_if u_if ();

   wb_stage #(.CNT_W(64), .EN_MISALIGN(1'b1)) u_dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .mem             (u_if.slave),
      .i_stall         (stall),
      .i_flush         (flush),
      .o_result_WB     (res_a),
      .o_addr_des_WB   (rd_a),
      .o_reg_write_WB  (we_a),
      .o_valid_WB      (v_a),
      .o_misaligned_WB (mis_a),
      .o_instret       (cnt_a)
   );

   wb_stage #(.CNT_W(4), .EN_MISALIGN(1'b0)) u_dut_nm (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .mem             (u_if.slave),
      .i_stall         (stall),
      .i_flush         (flush),
      .o_result_WB     (res_b),
      .o_addr_des_WB   (rd_b),
      .o_reg_write_WB  (we_b),
      .o_valid_WB      (v_b),
      .o_misaligned_WB (mis_b),
      .o_instret       (cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        rw;
      logic [1:0]  src;
      logic [2:0]  f3;
      logic [31:0] alu;
      logic [31:0] data;
      logic [4:0]  rd;
      logic [31:0] pc4;
      logic [31:0] e_res;
      logic        e_we;
      logic        e_mis;
      logic        e_we2;
   } vec_t;

   localparam int NV = 20;
   localparam logic [31:0] D = 32'h80FF7F01;

   vec_t        vt [NV];
   int          n_cmp;
   int          n_miss;
   logic [63:0] exp_cnt;
   logic        exp_v;

   function automatic vec_t mk(
      input logic v, input logic rw, input logic [1:0] src,
      input logic [2:0] f3, input logic [31:0] alu,
      input logic [31:0] data, input logic [4:0] rd,
      input logic [31:0] pc4, input logic [31:0] e_res,
      input logic e_we, input logic e_mis, input logic e_we2);
      vec_t x;
      x.v = v; x.rw = rw; x.src = src; x.f3 = f3;
      x.alu = alu; x.data = data; x.rd = rd; x.pc4 = pc4;
      x.e_res = e_res; x.e_we = e_we;
      x.e_mis = e_mis; x.e_we2 = e_we2;
      return x;
   endfunction

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      u_if.i_valid_MEM      = x.v;
      u_if.i_reg_write_MEM  = x.rw;
      u_if.i_result_src_MEM = x.src;
      u_if.i_funct3_MEM     = x.f3;
      u_if.i_alu_result_MEM = x.alu;
      u_if.i_data_MEM       = x.data;
      u_if.i_addr_des_MEM   = x.rd;
      u_if.i_pc_plus4_MEM   = x.pc4;
   endtask

   task automatic step(input logic st, input logic fl);
      stall = st;
      flush = fl;
      if (exp_v && (!st || fl))
         exp_cnt = exp_cnt + 64'd1;
      if (fl)
         exp_v = 1'b0;
      else if (!st)
         exp_v = u_if.i_valid_MEM;
      @(posedge clk);
      #1;
      stall = 1'b0;
      flush = 1'b0;
   endtask

   task automatic chk_cnt(input string nm);
      chk({nm, "_instret"}, cnt_a, exp_cnt);
      chk({nm, "_instret4"}, {60'h0, cnt_b}, {60'h0, exp_cnt[3:0]});
   endtask

   vec_t idle;
   vec_t a;
   vec_t b;

   initial begin
      n_cmp   = 0;
      n_miss  = 0;
      exp_cnt = 64'd0;
      exp_v   = 1'b0;
      stall   = 1'b0;
      flush   = 1'b0;
      rst_n   = 1'b0;

      //      v  rw src    f3      alu           data  rd pc4   res            we mis we2
      vt[0]  = mk(1, 1, 2'b00, 3'b000, 32'h1234, D, 5, 0, 32'h1234,     1, 0, 1);
      vt[1]  = mk(1, 1, 2'b01, 3'b000, 32'h1002, D, 6, 0, 32'hFFFFFFFF, 1, 0, 1);
      vt[2]  = mk(1, 1, 2'b01, 3'b100, 32'h1002, D, 6, 0, 32'h000000FF, 1, 0, 1);
      vt[3]  = mk(1, 1, 2'b01, 3'b001, 32'h1002, D, 7, 0, 32'hFFFF80FF, 1, 0, 1);
      vt[4]  = mk(1, 1, 2'b01, 3'b101, 32'h1002, D, 7, 0, 32'h000080FF, 1, 0, 1);
      vt[5]  = mk(1, 1, 2'b01, 3'b000, 32'h1000, D, 8, 0, 32'h00000001, 1, 0, 1);
      vt[6]  = mk(1, 1, 2'b01, 3'b000, 32'h1001, D, 8, 0, 32'h0000007F, 1, 0, 1);
      vt[7]  = mk(1, 1, 2'b01, 3'b100, 32'h1003, D, 8, 0, 32'h00000080, 1, 0, 1);
      vt[8]  = mk(1, 1, 2'b01, 3'b000, 32'h1003, D, 8, 0, 32'hFFFFFF80, 1, 0, 1);
      vt[9]  = mk(1, 1, 2'b01, 3'b001, 32'h1000, D, 9, 0, 32'h00007F01, 1, 0, 1);
      vt[10] = mk(1, 1, 2'b01, 3'b010, 32'h1000, D, 9, 0, 32'h80FF7F01, 1, 0, 1);
      vt[11] = mk(1, 1, 2'b01, 3'b010, 32'h1001, D, 9, 0, 32'h80FF7F01, 0, 1, 1);
      vt[12] = mk(1, 1, 2'b01, 3'b001, 32'h1001, D, 9, 0, 32'h00007F01, 0, 1, 1);
      vt[13] = mk(1, 1, 2'b01, 3'b011, 32'h1000, D, 9, 0, 32'h00000000, 0, 1, 1);
      vt[14] = mk(1, 1, 2'b00, 3'b000, 32'hDEAD, D, 0, 0, 32'h0000DEAD, 0, 0, 0);
      vt[15] = mk(1, 1, 2'b10, 3'b000, 32'h5555, D, 1, 32'h104, 32'h104, 1, 0, 1);
      vt[16] = mk(1, 1, 2'b11, 3'b000, 32'h5555, D, 2, 32'h104, 32'h0,   1, 0, 1);
      vt[17] = mk(1, 0, 2'b00, 3'b000, 32'h7777, D, 3, 0, 32'h7777,      0, 0, 0);
      vt[18] = mk(0, 1, 2'b00, 3'b000, 32'h4242, D, 4, 0, 32'h4242,      0, 0, 0);
      vt[19] = mk(1, 1, 2'b00, 3'b010, 32'h1001, D, 4, 0, 32'h1001,      1, 0, 1);

      idle = mk(0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(idle);

      #1;
      chk("rst_valid", {63'h0, v_a}, 64'h0);
      chk("rst_we", {63'h0, we_a}, 64'h0);
      chk("rst_result", {32'h0, res_a}, 64'h0);
      chk("rst_rd", {59'h0, rd_a}, 64'h0);
      chk("rst_mis", {63'h0, mis_a}, 64'h0);
      chk_cnt("rst");

      #11 rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vt[i]);
         step(1'b0, 1'b0);
         chk($sformatf("v%0d_result", i), {32'h0, res_a}, {32'h0, vt[i].e_res});
         chk($sformatf("v%0d_rd", i), {59'h0, rd_a}, {59'h0, vt[i].rd});
         chk($sformatf("v%0d_valid", i), {63'h0, v_a}, {63'h0, vt[i].v});
         chk($sformatf("v%0d_we", i), {63'h0, we_a}, {63'h0, vt[i].e_we});
         chk($sformatf("v%0d_mis", i), {63'h0, mis_a}, {63'h0, vt[i].e_mis});
         chk($sformatf("v%0d_we_nm", i), {63'h0, we_b}, {63'h0, vt[i].e_we2});
         chk($sformatf("v%0d_mis_nm", i), {63'h0, mis_b}, 64'h0);
         chk_cnt($sformatf("v%0d", i));
      end

      // Stall for three cycles: outputs frozen, counter held.
      a = mk(1, 1, 2'b00, 3'b000, 32'hAAAA, D, 10, 0, 0, 0, 0, 0);
      drive(a);
      step(1'b0, 1'b0);
      chk_cnt("stall_load");
      b = mk(1, 1, 2'b00, 3'b000, 32'hBBBB, D, 11, 0, 0, 0, 0, 0);
      drive(b);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0);
         chk($sformatf("stall%0d_result", k), {32'h0, res_a}, 64'hAAAA);
         chk($sformatf("stall%0d_rd", k), {59'h0, rd_a}, 64'd10);
         chk($sformatf("stall%0d_we", k), {63'h0, we_a}, 64'h1);
         chk_cnt($sformatf("stall%0d", k));
      end
      drive(idle);
      step(1'b0, 1'b0);
      chk("unstall_valid", {63'h0, v_a}, 64'h0);
      chk_cnt("unstall");

      // Stall and flush together: flush wins, outgoing entry retires.
      drive(a);
      step(1'b0, 1'b0);
      drive(b);
      step(1'b1, 1'b1);
      chk("stflush_valid", {63'h0, v_a}, 64'h0);
      chk("stflush_we", {63'h0, we_a}, 64'h0);
      chk_cnt("stflush");
      step(1'b0, 1'b1);
      chk("flush_valid", {63'h0, v_a}, 64'h0);
      chk_cnt("flush");

      // Asynchronous reset between edges.
      drive(a);
      step(1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      exp_cnt = 64'd0;
      exp_v   = 1'b0;
      chk("arst_valid", {63'h0, v_a}, 64'h0);
      chk("arst_we", {63'h0, we_a}, 64'h0);
      chk("arst_result", {32'h0, res_a}, 64'h0);
      chk("arst_rd", {59'h0, rd_a}, 64'h0);
      chk_cnt("arst");
      #2 rst_n = 1'b1;

      // Sixteen retirements wrap the 4-bit counter to zero.
      drive(a);
      for (int k = 0; k < 17; k++)
         step(1'b0, 1'b0);
      chk("wrap_instret", cnt_a, 64'd16);
      chk("wrap_instret4", {60'h0, cnt_b}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
      $finish;
   end

endmodule
